// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   uart_state_t         - frame FSM state encoding
//   PAR_NONE/ODD/EVEN    - parity mode selectors
//   UART_CLK_DIV_DEFAULT - clocks per bit (50 MHz / 115200)
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam int UART_CLK_DIV_DEFAULT = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer.
//   clk, reset - clock, synchronous active-high reset
//   clr        - restart the count at 0 on the next edge
//   tick       - high during the last clock of each bit period
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (cnt == CNT_LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmit stage with a one-byte holding register in
// front of the shift register, so the next byte can be staged mid-frame.
//   clk, reset    - clock, synchronous active-high reset
//   tx_load       - one-cycle strobe, tx_data captured on the same edge
//   tx_data       - byte to transmit
//   tx_buf_empty  - holding register empty (load accepted only when high)
//   tx_busy       - frame in progress on txd
//   tx_overrun    - sticky: load arrived while holding register full
//   txd           - serial line, idle high
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = UART_CLK_DIV_DEFAULT,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_load,
   input  logic [7:0] tx_data,
   output logic       tx_buf_empty,
   output logic       tx_busy,
   output logic       tx_overrun,
   output logic       txd
);

   localparam logic STOP_LAST = (STOP_BITS == 2);
   localparam logic PAR_INV   = (PARITY == PAR_ODD);

   uart_state_t state, state_next;

   logic [7:0] hold;
   logic       hold_full;
   logic [7:0] shift;
   logic       par_bit;
   logic [2:0] bit_cnt;
   logic       stop_cnt;
   logic       txd_r, txd_next;
   logic       overrun;
   logic       tick;
   logic       xfer;       // hold -> shifter, enter START
   logic       shift_adv;  // move to the next data bit

   uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clr   (xfer || (state == ST_IDLE)),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      txd_next   = txd_r;
      xfer       = 1'b0;
      shift_adv  = 1'b0;
      case (state)
         ST_IDLE:
            if (hold_full) xfer = 1'b1;
         ST_START:
            if (tick) begin
               state_next = ST_DATA;
               txd_next   = shift[0];
            end
         ST_DATA:
            if (tick) begin
               if (bit_cnt == 3'd7) begin
                  if (PARITY != PAR_NONE) begin
                     state_next = ST_PARITY;
                     txd_next   = par_bit;
                  end else begin
                     state_next = ST_STOP;
                     txd_next   = 1'b1;
                  end
               end else begin
                  shift_adv = 1'b1;
                  txd_next  = shift[1];
               end
            end
         ST_PARITY:
            if (tick) begin
               state_next = ST_STOP;
               txd_next   = 1'b1;
            end
         ST_STOP:
            if (tick && (stop_cnt == STOP_LAST)) begin
               // a staged byte starts on the very next bit, no idle gap
               if (hold_full) xfer = 1'b1;
               else           state_next = ST_IDLE;
            end
         default: begin
            state_next = ST_IDLE;
            txd_next   = 1'b1;
         end
      endcase
      if (xfer) begin
         state_next = ST_START;
         txd_next   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold      <= '0;
         hold_full <= 1'b0;
         shift     <= '0;
         par_bit   <= 1'b0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
         txd_r     <= 1'b1;
         overrun   <= 1'b0;
      end else begin
         txd_r <= txd_next;
         // a load while full is dropped even if the hold drains this edge
         if (tx_load && hold_full)
            overrun <= 1'b1;
         if (tx_load && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end else if (xfer) begin
            hold_full <= 1'b0;
         end
         if (xfer) begin
            shift    <= hold;
            par_bit  <= (^hold) ^ PAR_INV;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
         end else begin
            if (shift_adv)
               shift <= {1'b0, shift[7:1]};
            if ((state == ST_DATA) && tick)
               bit_cnt <= bit_cnt + 1'b1;
            if ((state == ST_STOP) && tick)
               stop_cnt <= ~stop_cnt;
         end
      end
   end

   assign tx_buf_empty = ~hold_full;
   assign tx_busy      = (state != ST_IDLE);
   assign tx_overrun   = overrun;
   assign txd          = txd_r;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: four instances with CLK_DIV=4 covering parity none/even/
// odd and two stop bits, all fed the same load stream. A line monitor on the
// selected instance checks each bit (level held for exactly 4 clocks) against
// frames the bench builds itself and queues when it drives a load.
module tb_uart_tx_core;

   localparam int DIV = 4;

   typedef struct {
      logic [11:0] bits;
      int          nbits;
   } frm_t;

   typedef struct {
      int         inst;
      logic [7:0] data;
      int         len;
      int         par_exp;   // -1: no parity bit to check
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_load = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [3:0] txd_v, empty_v, busy_v, ovr_v;

   int par_of  [4] = '{0, 2, 1, 0};
   int stop_of [4] = '{1, 1, 1, 2};

   int sel = 0;
   int checks = 0;
   int passed = 0;

   frm_t exp_q[$];

   always #5 clk = ~clk;

   uart_tx_core #(.CLK_DIV(DIV), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset), .tx_load(tx_load), .tx_data(tx_data),
      .tx_buf_empty(empty_v[0]), .tx_busy(busy_v[0]), .tx_overrun(ovr_v[0]), .txd(txd_v[0]));
   uart_tx_core #(.CLK_DIV(DIV), .PARITY(2), .STOP_BITS(1)) u1 (
      .clk(clk), .reset(reset), .tx_load(tx_load), .tx_data(tx_data),
      .tx_buf_empty(empty_v[1]), .tx_busy(busy_v[1]), .tx_overrun(ovr_v[1]), .txd(txd_v[1]));
   uart_tx_core #(.CLK_DIV(DIV), .PARITY(1), .STOP_BITS(1)) u2 (
      .clk(clk), .reset(reset), .tx_load(tx_load), .tx_data(tx_data),
      .tx_buf_empty(empty_v[2]), .tx_busy(busy_v[2]), .tx_overrun(ovr_v[2]), .txd(txd_v[2]));
   uart_tx_core #(.CLK_DIV(DIV), .PARITY(0), .STOP_BITS(2)) u3 (
      .clk(clk), .reset(reset), .tx_load(tx_load), .tx_data(tx_data),
      .tx_buf_empty(empty_v[3]), .tx_busy(busy_v[3]), .tx_overrun(ovr_v[3]), .txd(txd_v[3]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   function automatic frm_t build_frame(input logic [7:0] d, input int par, input int stop);
      frm_t f;
      f.bits = '0;
      f.bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
      f.nbits = 9;
      if (par != 0) begin
         f.bits[f.nbits] = (par == 2) ? (^d) : ~(^d);
         f.nbits++;
      end
      for (int i = 0; i < stop; i++) begin
         f.bits[f.nbits] = 1'b1;
         f.nbits++;
      end
      return f;
   endfunction

   // line monitor: one check per bit period
   logic in_frm = 1'b0;
   int   pos, sub, gap, last_gap;
   logic bad;
   frm_t cur;

   always @(negedge clk) begin
      if (reset) begin
         in_frm = 1'b0;
         gap    = 0;
      end else begin
         if (!in_frm) begin
            if (txd_v[sel] == 1'b0) begin
               in_frm = 1'b1; last_gap = gap; gap = 0;
               pos = 0; sub = 0; bad = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 32'd1, 32'd0);
                  cur.bits = '0; cur.nbits = 1;
               end else begin
                  cur = exp_q.pop_front();
               end
            end else begin
               gap++;
            end
         end
         if (in_frm) begin
            if (txd_v[sel] !== cur.bits[pos]) bad = 1'b1;
            sub++;
            if (sub == DIV) begin
               chk($sformatf("frame_bit%0d", pos), {31'd0, bad}, 32'd0);
               sub = 0; bad = 1'b0; pos++;
               if (pos == cur.nbits) in_frm = 1'b0;
            end
         end
      end
   end

   task automatic do_load(input logic [7:0] d);
      @(negedge clk);
      tx_load = 1'b1; tx_data = d;
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   // counts negedges with busy high, starting from index k
   task automatic wait_idle(inout int k, output logic par_s);
      par_s = 1'bx;
      while (busy_v[sel] && k < 300) begin
         if (k == 37) par_s = txd_v[sel];
         k++;
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int   k;
      logic p;
      sel = v.inst;
      exp_q.push_back(build_frame(v.data, par_of[v.inst], stop_of[v.inst]));
      do_load(v.data);
      chk("empty_fall", {31'd0, empty_v[sel]}, 32'd0);
      @(negedge clk);
      chk("start_state", {29'd0, txd_v[sel], busy_v[sel], empty_v[sel]}, 32'b011);
      k = 0;
      wait_idle(k, p);
      chk($sformatf("frame_len_%0h", v.data), k, v.len);
      if (v.par_exp >= 0) chk("parity_bit", {31'd0, p}, v.par_exp[31:0]);
      repeat (12) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   vec_t vecs[8];

   initial begin
      int   k;
      logic p;
      vecs[0] = '{0, 8'hA5, 40, -1};
      vecs[1] = '{1, 8'h07, 44,  1};
      vecs[2] = '{2, 8'h07, 44,  0};
      vecs[3] = '{3, 8'h07, 44, -1};
      vecs[4] = '{1, 8'h00, 44,  0};
      vecs[5] = '{2, 8'h00, 44,  1};
      vecs[6] = '{0, 8'hFF, 40, -1};
      vecs[7] = '{3, 8'h81, 44, -1};

      // reset then idle
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle", {txd_v, empty_v, busy_v, ovr_v}, 32'hFF00);
      end

      foreach (vecs[i]) run_vec(vecs[i]);

      // back-to-back: second byte staged as soon as the buffer reopens
      sel = 0;
      exp_q.push_back(build_frame(8'h55, 0, 1));
      do_load(8'h55);
      @(negedge clk);
      chk("b2b_empty_rise", {31'd0, empty_v[0]}, 32'd1);
      tx_load = 1'b1; tx_data = 8'h0F;
      exp_q.push_back(build_frame(8'h0F, 0, 1));
      @(negedge clk);
      tx_load = 1'b0;
      k = 1;
      wait_idle(k, p);
      chk("b2b_busy_len", k, 80);
      chk("b2b_gap", last_gap, 0);
      chk("b2b_no_overrun", {31'd0, ovr_v[0]}, 32'd0);
      chk("b2b_drained", exp_q.size(), 0);
      repeat (8) @(negedge clk);

      // overrun: A, skip a cycle, B, then C immediately -> C dropped
      exp_q.push_back(build_frame(8'hC3, 0, 1));
      exp_q.push_back(build_frame(8'h3A, 0, 1));
      do_load(8'hC3);
      @(negedge clk);
      tx_load = 1'b1; tx_data = 8'h3A;
      @(negedge clk);
      tx_data = 8'hEE;
      @(negedge clk);
      tx_load = 1'b0;
      chk("overrun_set", {31'd0, ovr_v[0]}, 32'd1);
      k = 2;
      wait_idle(k, p);
      chk("overrun_busy_len", k, 80);
      repeat (20) @(negedge clk);
      chk("overrun_sticky", {31'd0, ovr_v[0]}, 32'd1);
      chk("overrun_drained", exp_q.size(), 0);

      // reset during data bit 3, then a fresh frame
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("overrun_cleared", {31'd0, ovr_v[0]}, 32'd0);
      exp_q.push_back(build_frame(8'hA5, 0, 1));
      do_load(8'hA5);
      @(negedge clk);
      repeat (17) @(negedge clk);
      chk("mid_frame_busy", {31'd0, busy_v[0]}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_state", {29'd0, txd_v[0], busy_v[0], empty_v[0]}, 32'b101);
      reset = 1'b0;
      exp_q.delete();
      run_vec('{0, 8'h3C, 40, -1});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
